// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready input, persistent carry and shift-add multiply
// Single-cycle ops finish in IDLE; MUL runs WIDTH shift-add iterations in the MUL state.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_AND    = 5'b00001;
  localparam logic [4:0] OP_PASS_A = 5'b00010;
  localparam logic [4:0] OP_PASS_B = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b01100;
  localparam logic [4:0] OP_INC    = 5'b10100;
  localparam logic [4:0] OP_ADC    = 5'b00100;
  localparam logic [4:0] OP_SHL    = 5'b00101;
  localparam logic [4:0] OP_SHR    = 5'b00110;
  localparam logic [4:0] OP_MUL    = 5'b01000;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [0:0]         state;
  logic [WIDTH:0]     res;
  logic               undef;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign in_ready = (state == S_IDLE);

  // Bit WIDTH of res is carry-out for adds and borrow for SUB.
  always_comb begin
    res   = '0;
    undef = 1'b0;
    case (alu)
      OP_ADD:    res = {1'b0, a} + {1'b0, b};
      OP_ADC:    res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
      OP_INC:    res = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
      OP_SUB:    res = {1'b0, a} - {1'b0, b};
      OP_AND:    res = {1'b0, a & b};
      OP_PASS_A: res = {1'b0, a};
      OP_PASS_B: res = {1'b0, b};
      OP_SHL:    res = {a, 1'b0};
      OP_SHR:    res = {a[0], 1'b0, a[WIDTH-1:1]};
      default:   undef = 1'b1;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dout      <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (alu == OP_MUL) begin
              state  <= S_MUL;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              dout      <= res[WIDTH-1:0];
              carry     <= res[WIDTH];
              zero      <= (res[WIDTH-1:0] == '0);
              neg       <= res[WIDTH-1];
              out_valid <= 1'b1;
              err       <= undef;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            dout      <= acc_next[WIDTH-1:0];
            carry     <= |acc_next[2*WIDTH-1:WIDTH];
            zero      <= (acc_next[WIDTH-1:0] == '0);
            neg       <= acc_next[WIDTH-1];
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors
// Stimulus pushes expected responses; a negedge monitor pops one per out_valid.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] alu;
  logic [7:0] dout;
  logic       out_valid;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       err;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
    logic       n;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu(alu), .dout(dout), .out_valid(out_valid),
    .carry(carry), .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: dout 0x%0h with no pending op", dout);
      end else begin
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("carry", carry, e.c);
        chk("zero", zero, e.z);
        chk("neg", neg, e.n);
        chk("err", err, e.e);
      end
    end else if (err === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL err_without_out_valid: err 1, expected 0");
    end
  end

  // Waits for in_ready, presents the op for one accepting edge, leaves in_valid high.
  task automatic issue(input logic [4:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic push, input exp_t e);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 0, 1);
    alu = op;
    a = va;
    b = vb;
    in_valid = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busy_count(input int want);
    int cnt = 0;
    while (in_ready === 1'b0 && cnt < 40) begin
      in_valid = 1'b1;
      alu = 5'b00000;
      a = 8'h01;
      b = 8'h01;
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", cnt, want);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    alu = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    idle(1);

    // {dout, carry, zero, neg, err}
    issue(5'b00000, 8'hFF, 8'h01, 1'b1, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    issue(5'b00100, 8'h10, 8'h20, 1'b1, {8'h31, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(5'b01100, 8'h05, 8'h07, 1'b1, {8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});
    issue(5'b01100, 8'h07, 8'h07, 1'b1, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    issue(5'b10100, 8'hFF, 8'h00, 1'b1, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    issue(5'b00100, 8'h01, 8'h01, 1'b1, {8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(5'b00101, 8'h81, 8'h00, 1'b1, {8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(5'b00110, 8'h81, 8'h00, 1'b1, {8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(5'b00001, 8'hF0, 8'h3C, 1'b1, {8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(5'b00011, 8'h12, 8'h80, 1'b1, {8'h80, 1'b0, 1'b0, 1'b1, 1'b0});
    issue(5'b00010, 8'h7F, 8'h80, 1'b1, {8'h7F, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(1);

    issue(5'b01000, 8'h0F, 8'h11, 1'b1, {8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
    busy_count(8);
    issue(5'b01000, 8'h10, 8'h10, 1'b1, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    busy_count(8);
    idle(1);

    issue(5'b11111, 8'h55, 8'h00, 1'b1, {8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
    idle(2);

    // Multiply with 0x20*0x20 would leave carry=1; abort it two busy cycles in.
    issue(5'b01000, 8'h20, 8'h20, 1'b0, '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_dout", dout, 8'h00);
    chk("abort_carry", carry, 0);
    chk("abort_zero", zero, 1);
    chk("abort_neg", neg, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    idle(10);

    issue(5'b00000, 8'h01, 8'h02, 1'b1, {8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the processor datapath ALU. It adds a WIDTH parameter, a valid/ready input handshake, registered result and flag outputs, a carry flag that persists between operations (used by ADC), and a multi-cycle shift-add multiply. It sits between the register-file read ports and the writeback mux, and the control FSM sequences it via in_valid/in_ready/out_valid.

## Interface
- WIDTH, 8, operand and result width in bits (minimum 2).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented on a, b, alu.
- in_ready  output  1  the block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu  input  5  opcode.
- dout  output  WIDTH  registered result.
- out_valid  output  1  one-cycle pulse: dout and flags updated this cycle.
- carry  output  1  registered carry/borrow flag.
- zero  output  1  registered flag, 1 when dout == 0.
- neg  output  1  registered flag, dout[WIDTH-1].
- err  output  1  one-cycle pulse: an undefined opcode was accepted.

## Operation
- Opcodes (5 bits): ADD 00000, AND 00001, PASS_A 00010, PASS_B 00011, SUB 01100, INC 10100, ADC 00100, SHL 00101, SHR 00110, MUL 01000. All other codes are undefined.
- Arithmetic is computed in WIDTH+1 bits on zero-extended operands. dout = bits [WIDTH-1:0]; carry = bit WIDTH.
  - ADD: a+b. ADC: a+b+carry (the registered flag value). INC: a+1, so carry=1 iff a is all ones.
  - SUB: a-b. carry = borrow: 1 iff a < b unsigned.
  - AND, PASS_A, PASS_B: carry=0.
  - SHL: a<<1, with carry = a[WIDTH-1]. SHR: logical a>>1, with carry = a[0].
- MUL: unsigned a*b by shift-add, one partial product per cycle, WIDTH iterations.
  - dout = low WIDTH bits of the product.
  - carry = 1 iff the high WIDTH bits are nonzero (overflow).
- Undefined opcode: dout=0, carry=0, zero=1, neg=0. err pulses together with out_valid.
- zero and neg are always derived from the WIDTH-bit dout, never from the carry bit.
- Flags and dout change only on an out_valid cycle and otherwise hold their values.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid. Non-MUL opcode: stay in IDLE and register the result. MUL: go to MUL, load the multiplicand and multiplier, clear the accumulator and counter.
  - MUL: in_ready=0. Perform one iteration per cycle. After iteration WIDTH, register the result, pulse out_valid, and return to IDLE.
- in_valid while in_ready=0 is ignored: no queuing, no error.

## Timing
- Reset (synchronous): state=IDLE, dout=0, carry=0, zero=1, neg=0, out_valid=0, err=0, in_ready=1 in the cycle after the reset edge.
- Single-cycle ops: accepted at edge N; dout, flags, and out_valid=1 visible after edge N. Back-to-back acceptance every cycle is legal.
- Back-to-back ADC uses the carry produced by the immediately preceding operation.
- MUL: accepted at edge N; in_ready=0 after edges N..N+WIDTH-1. The result and out_valid appear after edge N+WIDTH. in_ready=1 after edge N+WIDTH, so a new op can be accepted at edge N+WIDTH+1.
- out_valid and err are high for exactly one cycle per accepted op.
- rst asserted during MUL aborts the multiply with no out_valid. All outputs take their reset values after that edge.
- rst has priority over in_valid on the same edge.

## Test plan
- Reset, WIDTH=8: assert rst for 2 cycles -> dout=0x00, carry=0, zero=1, neg=0, in_ready=1, out_valid=0.
- ADD 0xFF+0x01 -> dout=0x00, carry=1, zero=1, one out_valid pulse. Then ADC 0x10+0x20 next cycle -> dout=0x31, carry=0.
- SUB 0x05-0x07 -> dout=0xFE, carry=1, neg=1, zero=0. SUB 0x07-0x07 -> dout=0x00, carry=0, zero=1.
- MUL 0x0F*0x11 -> in_ready low for 8 cycles, dout=0xFF, carry=0. MUL 0x10*0x10 -> dout=0x00, carry=1, zero=1. in_valid pulses during busy are ignored.
- Undefined opcode 11111 with a=0x55 -> dout=0x00, zero=1, err and out_valid high for exactly 1 cycle.
- Reset mid-MUL (rst at cycle 3 of 8) -> no out_valid, reset values restored. An ADD 0x01+0x02 accepted next -> dout=0x03.
